// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the bus sources and the arbiter.
interface bus_arbiter_if;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       bus_valid;
  logic       timeout_err;

  modport master (output req, input gnt, input sel, input bus_valid, input timeout_err);
  modport slave  (input req, output gnt, output sel, output bus_valid, output timeout_err);
endinterface

// File: rtl/bus_arbiter.sv
// Registered 8-source bus arbiter: fixed or rotating priority, optional
// per-owner hold limit with forced revocation.
module bus_arbiter #(
  parameter bit          RR_EN   = 1'b1,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  bus_arbiter_if.slave  bus
);

  localparam int unsigned N_SRC = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = 4;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   last;
  logic [CNT_W-1:0]   hold_cnt;

  logic [N_SRC-1:0]   own_mask;
  logic [N_SRC-1:0]   arb_mask;
  logic [IDX_W-1:0]   base;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   win_idx;
  logic               win_vld;
  logic               timed_out;

  // Arbitration: scan descending from base-1, wrapping; base itself last.
  // Fixed priority is the same scan with base pinned to 0 (7 down to 0).
  always_comb begin
    own_mask        = '0;
    own_mask[owner] = 1'b1;
    arb_mask        = (state == BUSY) ? ~own_mask : {N_SRC{1'b1}};
    base            = RR_EN ? last : '0;
    idx             = '0;
    win_idx         = '0;
    win_vld         = 1'b0;
    for (int k = N_SRC; k >= 1; k--) begin
      idx = base - IDX_W'(k);
      if (bus.req[idx] && arb_mask[idx]) begin
        win_vld = 1'b1;
        win_idx = idx;
      end
    end
    timed_out = (TIMEOUT != 0) && (hold_cnt == CNT_W'(TIMEOUT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      owner           <= '0;
      last            <= '0;
      hold_cnt        <= '0;
      bus.gnt         <= '0;
      bus.sel         <= '0;
      bus.bus_valid   <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.timeout_err <= 1'b0;
      if (state == BUSY && bus.req[owner] && !timed_out) begin
        if (hold_cnt != {CNT_W{1'b1}}) hold_cnt <= hold_cnt + CNT_W'(1);
      end else begin
        // Owner released or revoked (or bus idle): hand over in the same edge.
        if (state == BUSY) bus.timeout_err <= bus.req[owner];
        if (win_vld) begin
          state         <= BUSY;
          owner         <= win_idx;
          last          <= win_idx;
          hold_cnt      <= CNT_W'(1);
          bus.gnt       <= N_SRC'(1) << win_idx;
          bus.sel       <= win_idx;
          bus.bus_valid <= 1'b1;
        end else begin
          state         <= IDLE;
          hold_cnt      <= '0;
          bus.gnt       <= '0;
          bus.sel       <= '0;
          bus.bus_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench: fixed-priority instance plus rotating instance with TIMEOUT=4.
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  bus_arbiter_if if_fx ();
  bus_arbiter_if if_rr ();

  bus_arbiter #(.RR_EN(1'b0), .TIMEOUT(0)) u_fx (.clk(clk), .rst(rst), .bus(if_fx));
  bus_arbiter #(.RR_EN(1'b1), .TIMEOUT(4)) u_rr (.clk(clk), .rst(rst), .bus(if_rr));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_rr(input string tag, input logic [7:0] g, input logic [2:0] s,
                          input logic v, input logic te);
    check_eq({tag, ".gnt"}, 32'(if_rr.gnt), 32'(g));
    check_eq({tag, ".sel"}, 32'(if_rr.sel), 32'(s));
    check_eq({tag, ".bv"},  32'(if_rr.bus_valid), 32'(v));
    check_eq({tag, ".te"},  32'(if_rr.timeout_err), 32'(te));
  endtask

  logic [7:0] exp_g  [10];
  logic [2:0] exp_s  [10];
  logic       exp_te [10];
  logic [2:0] rr_ord [7];

  initial begin
    if_fx.req = 8'h00;
    if_rr.req = 8'hFF;

    // Reset dominates requests
    tick();
    check_rr("rst0", 8'h00, 3'd0, 1'b0, 1'b0);
    check_eq("rst0.fx", 32'(if_fx.gnt), 32'h0);
    tick();
    check_rr("rst1", 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    check_rr("rst_rel", 8'h80, 3'd7, 1'b1, 1'b0);
    if_rr.req = 8'h00;

    // Fixed priority
    do_reset();
    if_fx.req = 8'h24;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("fx.hold.gnt", 32'(if_fx.gnt), 32'h20);
      check_eq("fx.hold.sel", 32'(if_fx.sel), 32'd5);
    end
    if_fx.req = 8'h04;
    tick();
    check_eq("fx.hand.gnt", 32'(if_fx.gnt), 32'h04);
    check_eq("fx.hand.sel", 32'(if_fx.sel), 32'd2);
    if_fx.req = 8'h84;
    tick();
    check_eq("fx.nopre", 32'(if_fx.gnt), 32'h04);
    if_fx.req = 8'h80;
    tick();
    check_eq("fx.hand7", 32'(if_fx.gnt), 32'h80);
    check_eq("fx.hand7.sel", 32'(if_fx.sel), 32'd7);
    if_fx.req = 8'h00;
    tick();
    check_eq("fx.idle.bv", 32'(if_fx.bus_valid), 32'd0);
    check_eq("fx.idle.sel", 32'(if_fx.sel), 32'd0);
    check_eq("fx.idle.gnt", 32'(if_fx.gnt), 32'h0);

    // Round robin, each owner releases for one cycle right after grant
    do_reset();
    rr_ord = '{3'd7, 3'd4, 3'd0, 3'd7, 3'd4, 3'd0, 3'd7};
    if_rr.req = 8'h91;
    tick();
    check_rr("rr0", 8'h80, 3'd7, 1'b1, 1'b0);
    for (int i = 1; i < 7; i++) begin
      if_rr.req = 8'h91 & ~(8'h01 << rr_ord[i-1]);
      tick();
      check_rr("rr", 8'h01 << rr_ord[i], rr_ord[i], 1'b1, 1'b0);
    end
    if_rr.req = 8'h00;
    tick();
    check_rr("rr.idle", 8'h00, 3'd0, 1'b0, 1'b0);

    // Timeout alternation between sources 3 and 1
    do_reset();
    exp_g  = '{8'h08, 8'h08, 8'h08, 8'h08, 8'h02, 8'h02, 8'h02, 8'h02, 8'h08, 8'h08};
    exp_s  = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd1, 3'd1, 3'd1, 3'd1, 3'd3, 3'd3};
    exp_te = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    if_rr.req = 8'h0A;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_rr("to2", exp_g[i], exp_s[i], 1'b1, exp_te[i]);
    end

    // Timeout with no competitor: one idle cycle then re-grant
    if_rr.req = 8'h00;
    do_reset();
    exp_g  = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00};
    exp_te = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    if_rr.req = 8'h01;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_rr("to1", exp_g[i], 3'd0, exp_g[i] != 8'h00, exp_te[i]);
    end

    // Reset mid-grant restores a full hold budget
    if_rr.req = 8'h00;
    do_reset();
    if_rr.req = 8'h40;
    tick();
    tick();
    check_rr("mid.pre", 8'h40, 3'd6, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    check_rr("mid.rst", 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_rr("mid.hold", 8'h40, 3'd6, 1'b1, 1'b0);
    end
    tick();
    check_rr("mid.to", 8'h00, 3'd0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Sequential arbiter that shares the 16-bit common bus among its eight source registers. Each source raises a request. The block grants exactly one source at a time and drives the 3-bit bus-multiplexer select. It sits in front of the bus multiplexer and replaces combinational priority encoding of the source-enable vector with registered, fair, time-bounded ownership.

## Interface
Parameters:
- RR_EN, default 1: 1 = rotating priority, 0 = fixed priority (index 7 highest).
- TIMEOUT, default 15: maximum consecutive grant cycles per owner, range 1–15; 0 disables the limit.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- req, input, 8: request vector; req[i] = source i wants the bus; held high for as long as ownership is wanted.
- gnt, output, 8: registered one-hot grant; all zeros when the bus is free.
- sel, output, 3: registered bus-mux select, binary index of the granted source.
- bus_valid, output, 1: registered; 1 while any grant is active.
- timeout_err, output, 1: registered single-cycle pulse on forced revocation.

## Operation
- States: IDLE (no owner) and BUSY (owner valid). Internal registers:
  - owner[2:0]
  - last[2:0], the most recent owner
  - hold_cnt[3:0]
- Reset, applied on any edge with rst=1, including mid-grant:
  - state=IDLE, gnt=0, sel=3'b000, bus_valid=0, timeout_err=0, last=3'b000, hold_cnt=0.
- Arbitration function win(mask):
  - RR_EN=0: search indices 7 down to 0; first i with req[i] & mask[i] wins.
  - RR_EN=1: search descending starting at (last-1) mod 8 and wrapping; last itself is searched last.
  - After reset, last=0, so the first RR arbitration starts at 7 and behaves like fixed priority.
- IDLE:
  - If req != 0: win(8'hFF) becomes owner. gnt=onehot(owner), sel=owner, bus_valid=1, hold_cnt=1, last=owner. Go to BUSY.
  - Otherwise stay in IDLE with outputs zero.
- BUSY, normal hold (req[owner]=1 and not timed out): hold outputs; hold_cnt increments.
- BUSY, release (req[owner]=0): on the same edge, re-arbitrate with win(~onehot(owner)).
  - If there is a winner: grant it directly (BUSY→BUSY, no idle bubble). hold_cnt=1, last=new owner.
  - Otherwise go to IDLE and clear outputs.
- BUSY, timeout (TIMEOUT≠0, hold_cnt==TIMEOUT, req[owner]=1):
  - Forced revocation: timeout_err=1 for one cycle.
  - Re-arbitrate with win(~onehot(owner)). If another source is requesting, it is granted; otherwise go to IDLE.
  - The revoked source may win again at the next arbitration if it is still requesting.
- Invariants:
  - gnt is always zero or one-hot.
  - sel==index(gnt) whenever bus_valid=1.
  - sel=0 when bus_valid=0.
  - Requests from non-owners never disturb the current owner.

## Timing
- Grant latency is 1 cycle: req rising before edge k gives gnt/sel/bus_valid valid after edge k.
- Handover takes 1 cycle: owner drops req before edge k; the new owner's gnt is valid after edge k. The old and new grants never overlap.
- Minimum ownership is 1 cycle.
- With TIMEOUT=T, an owner holds for at most T consecutive cycles.
- timeout_err is high for exactly the cycle following the revoking edge.
- Simultaneous owner release and new requests: the new request is included in the same arbitration.
- Simultaneous rst and any request: reset wins. The first grant can appear no earlier than the edge after rst deasserts.
- No combinational path from req to any output.

## Test plan
- Reset/idle:
  - Stimulus: rst=1 for 2 cycles while req=8'hFF.
  - Required: gnt=0, sel=0, bus_valid=0, timeout_err=0 throughout. After release, gnt=8'h80 and sel=3'b111 one cycle later.
- Fixed priority (RR_EN=0, TIMEOUT=0):
  - Stimulus: req=8'h24 held.
  - Required: gnt=8'h20, sel=5 indefinitely.
  - Stimulus: drop req[5].
  - Required: next cycle gnt=8'h04, sel=2. Drop req[2]: next cycle bus_valid=0, sel=0.
- Round robin (RR_EN=1):
  - Stimulus: req=8'h91; each owner drops and re-raises its request immediately after its grant.
  - Required: grant order 7, 4, 0, 7, 4, ... with no idle cycle between grants.
- Timeout (TIMEOUT=4):
  - Stimulus: req=8'h0A held constantly.
  - Required: source 3 is granted for 4 cycles, then timeout_err pulses once and gnt=8'h02 for 4 cycles. Grants then alternate on the same pattern.
- Timeout with no competitor (TIMEOUT=4):
  - Stimulus: req=8'h01 held.
  - Required: 4 cycles granted, then 1 cycle with bus_valid=0 and timeout_err=1, then re-granted.
- Reset mid-grant:
  - Stimulus: while owner=6 with hold_cnt=2, assert rst for one cycle with req=8'h40 held.
  - Required: the outputs are zero in the cycle after the reset edge. gnt=8'h40 reappears one cycle after rst is released, with hold_cnt restarting at 1 and a full TIMEOUT budget.
